// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - sequencer for a serial/parallel multiplier array (signed WIDTH x WIDTH -> 2*WIDTH)
// Optional zero-operand fast path compiled in with `define SPM_SEQ_ZERO_BYPASS_EN.
module spm_seq #(
  parameter int WIDTH = 32,
  parameter int PLAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 spm_rst,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  input  logic                 spm_p
);

  localparam int RUN_LEN = 2*WIDTH + PLAT;
  localparam int CW      = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(PLAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   out_p_d;
  logic [WIDTH-1:0]     spm_x_d;
  logic                 spm_rst_d;
  logic                 spm_y_d;
  logic                 in_ready_d;
  logic                 out_valid_d;
  logic                 accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      prod_q    <= '0;
      out_p     <= '0;
      spm_x     <= '0;
      spm_rst   <= 1'b0;
      spm_y     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      prod_q    <= prod_d;
      out_p     <= out_p_d;
      spm_x     <= spm_x_d;
      spm_rst   <= spm_rst_d;
      spm_y     <= spm_y_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Outputs are registered, so every branch sets the value for the next cycle.
  // y_q is arithmetically shifted each step: its LSB is always the next serial
  // bit, and the sign bit replicates itself for the upper WIDTH positions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    prod_d      = prod_q;
    out_p_d     = out_p;
    spm_x_d     = spm_x;
    spm_rst_d   = 1'b1;
    spm_y_d     = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          in_ready_d = 1'b0;
`ifdef SPM_SEQ_ZERO_BYPASS_EN
          if ((in_x == '0) || (in_y == '0)) begin
            state_d     = DONE;
            prod_d      = '0;
            out_p_d     = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d   = CLEAR;
            spm_x_d   = in_x;
            y_d       = in_y;
            prod_d    = '0;
            cnt_d     = '0;
            spm_rst_d = 1'b0;
          end
`else
          state_d   = CLEAR;
          spm_x_d   = in_x;
          y_d       = in_y;
          prod_d    = '0;
          cnt_d     = '0;
          spm_rst_d = 1'b0;
`endif
        end
      end

      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
        spm_y_d = y_q[0];
        y_d     = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
      end

      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CNT_CAP) begin
          prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_p_d     = prod_d;
          out_valid_d = 1'b1;
        end else begin
          // Positions 2*WIDTH and above feed zeros while the pipeline drains.
          if (cnt_q < CW'(2*WIDTH - 1)) begin
            spm_y_d = y_q[0];
          end
          y_d = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
        end
      end

      DONE: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
